// File: rtl/tcb_if.sv
// tcb_if: request/response bus monitor with response alignment, byte masking, protocol checks and counters.
module tcb_if #(
  parameter int DLY = 1,
  parameter int ADR = 32,
  parameter int DAT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic             wen,
  input  logic             ren,
  input  logic             ndn,
  input  logic [ADR-1:0]   adr,
  input  logic [2:0]       siz,
  input  logic [DAT/8-1:0] ben,
  input  logic [DAT-1:0]   wdt,
  input  logic             rdy,
  input  logic [DAT-1:0]   rdt,
  input  logic [7:0]       sts,
  output logic             trn,
  output logic             stl,
  output logic             idl,
  output logic             rsp_vld,
  output logic             d_wen,
  output logic             d_ren,
  output logic [ADR-1:0]   d_adr,
  output logic [2:0]       d_siz,
  output logic [DAT/8-1:0] d_ben,
  output logic [DAT-1:0]   rsp_dat,
  output logic             err_aln,
  output logic             err_ben,
  output logic [31:0]      trn_cnt,
  output logic [31:0]      stl_cnt
);
  localparam int BYT = DAT / 8;
  localparam int OFF = $clog2(BYT);
  localparam int OW  = (OFF > 0) ? OFF : 1;
  localparam int PW  = 3 + ADR + 3 + BYT;
  logic [OW-1:0]    lo;
  logic [OW-1:0]    aln_msk;
  logic [2*BYT-1:0] exp_ben;
  logic [PW-1:0]    cur;
  logic [PW-1:0]    dly;
  logic             unused_ok;
  assign trn = vld & rdy;
  assign stl = vld & ~rdy;
  assign idl = ~vld;
  assign lo  = (OFF > 0) ? adr[OW-1:0] : '0;
  assign unused_ok = ^{wdt, sts};
  always_comb begin
    aln_msk = OW'((32'd1 << siz) - 32'd1);
    exp_ben = (((2*BYT)'(1) << (32'd1 << siz)) - (2*BYT)'(1)) << lo;
    err_aln = vld & ((32'(siz) > OFF) | (|(lo & aln_msk)));
    err_ben = vld & ((wen == ren) | (~ndn & (32'(siz) <= OFF) & ({{BYT{1'b0}}, ben} != exp_ben)));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      trn_cnt <= '0;
      stl_cnt <= '0;
    end else begin
      trn_cnt <= trn_cnt + 32'(trn);
      stl_cnt <= stl_cnt + 32'(stl);
    end
  assign cur = {trn, wen, ren, adr, siz, ben};
  // Stages shift unconditionally so responses stay a fixed DLY after their transfer.
  if (DLY == 0) begin : g_comb
    assign dly = cur;
  end else begin : g_pipe
    logic [PW-1:0] stg [DLY];
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        for (int i = 0; i < DLY; i++) stg[i] <= '0;
      end else begin
        stg[0] <= cur;
        for (int i = 1; i < DLY; i++) stg[i] <= stg[i-1];
      end
    assign dly = stg[DLY-1];
  end
  assign {rsp_vld, d_wen, d_ren, d_adr, d_siz, d_ben} = dly;
  always_comb begin
    rsp_dat = '0;
    for (int i = 0; i < BYT; i++) rsp_dat[8*i +: 8] = (d_ren & d_ben[i]) ? rdt[8*i +: 8] : 8'h00;
  end
endmodule

// File: tb/tb_tcb_if.sv
// tb_tcb_if: directed bench driving DLY=0/1/2 instances of tcb_if from shared manager/subordinate signals.
module tb_tcb_if;
  logic        clk = 0;
  logic        rst = 0;
  logic        vld = 0, wen = 0, ren = 0, ndn = 0, rdy = 0;
  logic [31:0] adr = 0, wdt = 0, rdt = 0;
  logic [2:0]  siz = 0;
  logic [3:0]  ben = 0;
  logic [7:0]  sts = 0;
  int vec = 0, err = 0;
  logic        trn_0, stl_0, idl_0, rsp_vld_0, d_wen_0, d_ren_0, err_aln_0, err_ben_0;
  logic        trn_1, stl_1, idl_1, rsp_vld_1, d_wen_1, d_ren_1, err_aln_1, err_ben_1;
  logic        trn_2, stl_2, idl_2, rsp_vld_2, d_wen_2, d_ren_2, err_aln_2, err_ben_2;
  logic [31:0] d_adr_0, d_adr_1, d_adr_2, rsp_dat_0, rsp_dat_1, rsp_dat_2;
  logic [31:0] trn_cnt_0, trn_cnt_1, trn_cnt_2, stl_cnt_0, stl_cnt_1, stl_cnt_2;
  logic [2:0]  d_siz_0, d_siz_1, d_siz_2;
  logic [3:0]  d_ben_0, d_ben_1, d_ben_2;

  always #5 clk = ~clk;

  tcb_if #(.DLY(0)) u0 (.clk(clk), .rst(rst), .vld(vld), .wen(wen), .ren(ren), .ndn(ndn), .adr(adr), .siz(siz),
    .ben(ben), .wdt(wdt), .rdy(rdy), .rdt(rdt), .sts(sts), .trn(trn_0), .stl(stl_0), .idl(idl_0),
    .rsp_vld(rsp_vld_0), .d_wen(d_wen_0), .d_ren(d_ren_0), .d_adr(d_adr_0), .d_siz(d_siz_0), .d_ben(d_ben_0),
    .rsp_dat(rsp_dat_0), .err_aln(err_aln_0), .err_ben(err_ben_0), .trn_cnt(trn_cnt_0), .stl_cnt(stl_cnt_0));
  tcb_if #(.DLY(1)) u1 (.clk(clk), .rst(rst), .vld(vld), .wen(wen), .ren(ren), .ndn(ndn), .adr(adr), .siz(siz),
    .ben(ben), .wdt(wdt), .rdy(rdy), .rdt(rdt), .sts(sts), .trn(trn_1), .stl(stl_1), .idl(idl_1),
    .rsp_vld(rsp_vld_1), .d_wen(d_wen_1), .d_ren(d_ren_1), .d_adr(d_adr_1), .d_siz(d_siz_1), .d_ben(d_ben_1),
    .rsp_dat(rsp_dat_1), .err_aln(err_aln_1), .err_ben(err_ben_1), .trn_cnt(trn_cnt_1), .stl_cnt(stl_cnt_1));
  tcb_if #(.DLY(2)) u2 (.clk(clk), .rst(rst), .vld(vld), .wen(wen), .ren(ren), .ndn(ndn), .adr(adr), .siz(siz),
    .ben(ben), .wdt(wdt), .rdy(rdy), .rdt(rdt), .sts(sts), .trn(trn_2), .stl(stl_2), .idl(idl_2),
    .rsp_vld(rsp_vld_2), .d_wen(d_wen_2), .d_ren(d_ren_2), .d_adr(d_adr_2), .d_siz(d_siz_2), .d_ben(d_ben_2),
    .rsp_dat(rsp_dat_2), .err_aln(err_aln_2), .err_ben(err_ben_2), .trn_cnt(trn_cnt_2), .stl_cnt(stl_cnt_2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    vld = 0; rdy = 0; rst = 0;
    tick; tick;
    rst = 1;
  endtask

  task automatic test_reset;
    vld = 0; rdy = 0; rst = 0;
    tick; tick;
    vec++; if (rsp_vld_1 !== 1'b0) begin err++; $display("FAIL reset_rsp_vld: got %b want 0", rsp_vld_1); end
    vec++; if (d_adr_2 !== 32'h0) begin err++; $display("FAIL reset_d_adr: got %h want 0", d_adr_2); end
    vec++; if (trn_cnt_1 !== 32'h0 || stl_cnt_1 !== 32'h0) begin err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", trn_cnt_1, stl_cnt_1); end
    vec++; if (idl_1 !== 1'b1) begin err++; $display("FAIL reset_idl: got %b want 1", idl_1); end
    rst = 1;
  endtask

  task automatic test_byte_writes;
    logic [7:0] wd [4] = '{8'h01, 8'h23, 8'h45, 8'h67};
    do_reset;
    for (int k = 0; k < 4; k++) begin
      vld = 1; rdy = 1; wen = 1; ren = 0; ndn = 0; siz = 0; adr = 32'(k); ben = 4'(1 << k); wdt = 32'(wd[k]);
      #1;
      vec++; if ({trn_1, err_aln_1, err_ben_1} !== 3'b100) begin err++; $display("FAIL bw_trn_err[%0d]: got %b want 100", k, {trn_1, err_aln_1, err_ben_1}); end
      vec++; if (rsp_vld_1 !== (k > 0)) begin err++; $display("FAIL bw_rsp_vld[%0d]: got %b want %b", k, rsp_vld_1, k > 0); end
      if (k > 0) begin
        vec++; if (d_adr_1 !== 32'(k - 1)) begin err++; $display("FAIL bw_d_adr[%0d]: got %h want %h", k, d_adr_1, k - 1); end
      end
      tick;
    end
    vld = 0;
    #1;
    vec++; if (rsp_vld_1 !== 1'b1 || d_adr_1 !== 32'h3) begin err++; $display("FAIL bw_last: got %b/%h want 1/3", rsp_vld_1, d_adr_1); end
    vec++; if (trn_cnt_1 !== 32'd4) begin err++; $display("FAIL bw_trn_cnt: got %0d want 4", trn_cnt_1); end
    tick;
    vec++; if (rsp_vld_1 !== 1'b0) begin err++; $display("FAIL bw_end: got %b want 0", rsp_vld_1); end
  endtask

  task automatic test_halfword_read;
    do_reset;
    vld = 1; rdy = 1; wen = 0; ren = 1; ndn = 0; siz = 1; adr = 32'h12; ben = 4'b1100;
    #1;
    vec++; if ({err_aln_1, err_ben_1} !== 2'b00) begin err++; $display("FAIL hw_err: got %b want 00", {err_aln_1, err_ben_1}); end
    tick;
    vld = 0; rdt = 32'h4567_ABCD;
    #1;
    vec++; if (rsp_vld_1 !== 1'b1 || rsp_dat_1 !== 32'h4567_0000) begin err++; $display("FAIL hw_rsp_dat: got %b/%h want 1/45670000", rsp_vld_1, rsp_dat_1); end
    vec++; if (d_siz_1 !== 3'd1 || d_ben_1 !== 4'b1100 || d_ren_1 !== 1'b1) begin err++; $display("FAIL hw_fields: got %0d/%b/%b want 1/1100/1", d_siz_1, d_ben_1, d_ren_1); end
  endtask

  task automatic test_backpressure;
    do_reset;
    vld = 1; rdy = 0; wen = 0; ren = 1; siz = 2; adr = 32'h40; ben = 4'hF;
    #1;
    vec++; if ({trn_1, stl_1, idl_1} !== 3'b010) begin err++; $display("FAIL bp_stl0: got %b want 010", {trn_1, stl_1, idl_1}); end
    tick;
    vec++; if (stl_1 !== 1'b1 || rsp_vld_1 !== 1'b0) begin err++; $display("FAIL bp_stl1: got %b/%b want 1/0", stl_1, rsp_vld_1); end
    tick;
    rdy = 1;
    #1;
    vec++; if ({trn_1, stl_1} !== 2'b10 || rsp_vld_1 !== 1'b0) begin err++; $display("FAIL bp_trn: got %b/%b want 10/0", {trn_1, stl_1}, rsp_vld_1); end
    tick;
    vld = 0; rdy = 0;
    #1;
    vec++; if (rsp_vld_1 !== 1'b1) begin err++; $display("FAIL bp_rsp: got %b want 1", rsp_vld_1); end
    vec++; if (stl_cnt_1 !== 32'd2 || trn_cnt_1 !== 32'd1) begin err++; $display("FAIL bp_cnt: got %0d/%0d want 2/1", stl_cnt_1, trn_cnt_1); end
    tick;
    vec++; if (rsp_vld_1 !== 1'b0) begin err++; $display("FAIL bp_single: got %b want 0", rsp_vld_1); end
  endtask

  task automatic test_errors;
    vld = 1; rdy = 0; wen = 1; ren = 0; ndn = 0;
    siz = 2; adr = 32'h22; ben = 4'hF; #1;
    vec++; if (err_aln_1 !== 1'b1) begin err++; $display("FAIL err_a: got %b want 1", err_aln_1); end
    siz = 0; adr = 32'h1; ben = 4'b0001; #1;
    vec++; if ({err_aln_1, err_ben_1} !== 2'b01) begin err++; $display("FAIL err_b: got %b want 01", {err_aln_1, err_ben_1}); end
    siz = 3; adr = 32'h0; ben = 4'hF; #1;
    vec++; if (err_aln_1 !== 1'b1) begin err++; $display("FAIL err_c: got %b want 1", err_aln_1); end
    siz = 2; adr = 32'h8; ben = 4'hF; ren = 1; #1;
    vec++; if ({err_aln_1, err_ben_1} !== 2'b01) begin err++; $display("FAIL err_wen_ren: got %b want 01", {err_aln_1, err_ben_1}); end
    ren = 0; ndn = 1; siz = 0; adr = 32'h1; ben = 4'b0001; #1;
    vec++; if (err_ben_1 !== 1'b0) begin err++; $display("FAIL err_ndn: got %b want 0", err_ben_1); end
    vld = 0; ndn = 0; siz = 2; adr = 32'h22; #1;
    vec++; if ({err_aln_1, err_ben_1} !== 2'b00) begin err++; $display("FAIL err_idle: got %b want 00", {err_aln_1, err_ben_1}); end
  endtask

  task automatic test_dly0;
    do_reset;
    vld = 1; rdy = 1; wen = 0; ren = 1; siz = 2; adr = 32'h0; ben = 4'hF; rdt = 32'h89AB_CDEF; wdt = 32'h5555_5555;
    #1;
    vec++; if (rsp_vld_0 !== trn_0 || rsp_vld_0 !== 1'b1) begin err++; $display("FAIL d0_rsp_vld: got %b want 1", rsp_vld_0); end
    vec++; if (rsp_dat_0 !== 32'h89AB_CDEF) begin err++; $display("FAIL d0_rsp_dat: got %h want 89abcdef", rsp_dat_0); end
    siz = 1; ben = 4'b0011; wdt = 32'hAAAA_AAAA; #1;
    vec++; if (rsp_dat_0 !== 32'h0000_CDEF || d_siz_0 !== 3'd1) begin err++; $display("FAIL d0_half: got %h/%0d want 0000cdef/1", rsp_dat_0, d_siz_0); end
    wen = 1; ren = 0; #1;
    vec++; if (rsp_dat_0 !== 32'h0) begin err++; $display("FAIL d0_write_dat: got %h want 0", rsp_dat_0); end
    vld = 0; #1;
    vec++; if (rsp_vld_0 !== 1'b0) begin err++; $display("FAIL d0_idle: got %b want 0", rsp_vld_0); end
    tick;
  endtask

  task automatic test_back_to_back;
    do_reset;
    vld = 1; rdy = 1; wen = 1; ren = 0; siz = 2; adr = 32'h4; ben = 4'hF;
    tick;
    adr = 32'h8; #1;
    vec++; if (rsp_vld_2 !== 1'b0) begin err++; $display("FAIL b2b_early: got %b want 0", rsp_vld_2); end
    tick;
    vld = 0; #1;
    vec++; if (rsp_vld_2 !== 1'b1 || d_adr_2 !== 32'h4) begin err++; $display("FAIL b2b_first: got %b/%h want 1/4", rsp_vld_2, d_adr_2); end
    tick;
    vec++; if (rsp_vld_2 !== 1'b1 || d_adr_2 !== 32'h8) begin err++; $display("FAIL b2b_second: got %b/%h want 1/8", rsp_vld_2, d_adr_2); end
    vec++; if (trn_cnt_2 !== 32'd2) begin err++; $display("FAIL b2b_cnt: got %0d want 2", trn_cnt_2); end
    tick;
    vec++; if (rsp_vld_2 !== 1'b0) begin err++; $display("FAIL b2b_end: got %b want 0", rsp_vld_2); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    vld = 1; rdy = 0; ren = 1; wen = 0; siz = 2; adr = 32'h0; ben = 4'hF;
    tick;
    rdy = 1;
    tick;
    vld = 0; #1;
    rst = 0; #1;
    vec++; if (rsp_vld_2 !== 1'b0 || trn_cnt_2 !== 32'h0 || stl_cnt_2 !== 32'h0) begin err++; $display("FAIL rm_clear: got %b/%0d/%0d want 0/0/0", rsp_vld_2, trn_cnt_2, stl_cnt_2); end
    vld = 1; rdy = 0; #1;
    vec++; if (stl_2 !== 1'b1) begin err++; $display("FAIL rm_comb: got %b want 1", stl_2); end
    vld = 0;
    tick;
    rst = 1;
    for (int c = 0; c < 3; c++) begin
      tick;
      vec++; if (rsp_vld_2 !== 1'b0) begin err++; $display("FAIL rm_no_rsp[%0d]: got %b want 0", c, rsp_vld_2); end
    end
  endtask

  initial begin
    test_reset;
    test_byte_writes;
    test_halfword_read;
    test_backpressure;
    test_errors;
    test_dly0;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
